dm_port_arbiter: RTL

Sequences all accesses to the single-port data-memory block RAM and shares it between the CPU MEM stage and a word-wide DMA/loader port. It generates byte enables and replicated write data for sub-word stores, and detects misaligned accesses. It stalls each requester until its access completes and returns sign- or zero-extended load data using the load/store size code. It sits between the MEM stage and the data-memory RAM.

---
 rtl/dm_port_arbiter_pkg.sv | 39 +++
 rtl/dm_port_arbiter_store_align.sv | 38 +++
 rtl/dm_port_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dm_port_arbiter_pkg: size codes, FSM states and helpers for the data-memory port arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dm_port_arbiter_pkg;

   localparam logic [2:0] L_S_B  = 3'b000;
   localparam logic [2:0] L_S_H  = 3'b001;
   localparam logic [2:0] L_S_W  = 3'b010;
   localparam logic [2:0] L_S_BU = 3'b100;
   localparam logic [2:0] L_S_HU = 3'b101;

   typedef enum logic [1:0] {
      DMA_IDLE   = 2'd0,
      DMA_RD_CPU = 2'd1,
      DMA_RD_DMA = 2'd2
   } dm_state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } dm_owner_e;

   function automatic logic is_misaligned(input logic [2:0] lssl, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (lssl)
         L_S_W:          mis = (off != 2'b00);
         L_S_H, L_S_HU:  mis = off[0];
         default:        mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dm_port_arbiter_store_align.sv
// ----------------------------------------------------------------------------
// dm_store_align: byte enables and lane-replicated write data for sub-word stores.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dm_store_align
   import dm_port_arbiter_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  lssl,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_out
);

   always_comb begin
      be        = 4'b1111;
      wdata_out = wdata;
      case (lssl)
         L_S_H, L_S_HU: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_out = {wdata[15:0], wdata[15:0]};
         end
         L_S_B, L_S_BU: begin
            be        = 4'b0001 << addr_lo;
            wdata_out = {4{wdata[7:0]}};
         end
         default: begin
            be        = 4'b1111;
            wdata_out = wdata;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dm_port_arbiter.sv
// ----------------------------------------------------------------------------
// dm_port_arbiter: round-robin sharing of the single-port data RAM between CPU and DMA.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dm_port_arbiter
   import dm_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [2:0]        cpu_lssl,
   output logic              cpu_stall,
   output logic              cpu_valid,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_exc,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [31:0]       dma_addr,
   input  logic [31:0]       dma_wdata,
   output logic              dma_gnt,
   output logic              dma_valid,
   output logic [31:0]       dma_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   dm_state_e   state_q, state_d;
   dm_owner_e   last_gnt_q, last_gnt_d;
   logic [1:0]  rd_off_q, rd_off_d;
   logic [2:0]  rd_lssl_q, rd_lssl_d;

   logic [3:0]  cpu_be;
   logic [31:0] cpu_al_wdata;
   logic        cpu_mis, cpu_elig, idle, gnt_cpu, gnt_dma;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        unused_bits;

   assign unused_bits = &{1'b0, cpu_addr[31:ADDR_W+2], dma_addr[31:ADDR_W+2], dma_addr[1:0]};

   dm_store_align u_store_align (
      .addr_lo   (cpu_addr[1:0]),
      .lssl      (cpu_lssl),
      .wdata     (cpu_wdata),
      .be        (cpu_be),
      .wdata_out (cpu_al_wdata)
   );

   assign idle     = (state_q == DMA_IDLE);
   assign cpu_mis  = is_misaligned(cpu_lssl, cpu_addr[1:0]);
   assign cpu_elig = cpu_req & ~cpu_mis;
   // On a tie the side that did not win last time gets the slot.
   assign gnt_cpu  = idle & cpu_elig & (~dma_req | (last_gnt_q == OWN_DMA));
   assign gnt_dma  = idle & dma_req & ~gnt_cpu;

   always_comb begin
      case (rd_off_q)
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = rd_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      rd_off_d   = rd_off_q;
      rd_lssl_d  = rd_lssl_q;
      cpu_valid  = 1'b0;
      cpu_rdata  = 32'd0;
      cpu_exc    = 1'b0;
      dma_gnt    = 1'b0;
      dma_valid  = 1'b0;
      dma_rdata  = 32'd0;
      mem_en     = 1'b0;
      mem_be     = 4'b0000;
      mem_addr   = '0;
      mem_wdata  = 32'd0;
      case (state_q)
         DMA_IDLE: begin
            cpu_exc = cpu_req & cpu_mis;
            if (gnt_cpu) begin
               mem_en     = 1'b1;
               mem_addr   = cpu_addr[ADDR_W+1:2];
               last_gnt_d = OWN_CPU;
               if (cpu_we) begin
                  mem_be    = cpu_be;
                  mem_wdata = cpu_al_wdata;
               end else begin
                  state_d   = DMA_RD_CPU;
                  rd_off_d  = cpu_addr[1:0];
                  rd_lssl_d = cpu_lssl;
               end
            end else if (gnt_dma) begin
               dma_gnt    = 1'b1;
               mem_en     = 1'b1;
               mem_addr   = dma_addr[ADDR_W+1:2];
               last_gnt_d = OWN_DMA;
               if (dma_we) begin
                  mem_be    = 4'b1111;
                  mem_wdata = dma_wdata;
               end else begin
                  state_d = DMA_RD_DMA;
               end
            end
         end
         DMA_RD_CPU: begin
            cpu_valid = 1'b1;
            case (rd_lssl_q)
               L_S_B:   cpu_rdata = {{24{ld_byte[7]}}, ld_byte};
               L_S_BU:  cpu_rdata = {24'd0, ld_byte};
               L_S_H:   cpu_rdata = {{16{ld_half[15]}}, ld_half};
               L_S_HU:  cpu_rdata = {16'd0, ld_half};
               default: cpu_rdata = mem_rdata;
            endcase
            state_d = DMA_IDLE;
         end
         DMA_RD_DMA: begin
            dma_valid = 1'b1;
            dma_rdata = mem_rdata;
            state_d   = DMA_IDLE;
         end
         default: state_d = DMA_IDLE;
      endcase
      cpu_stall = cpu_req & ~((gnt_cpu & cpu_we) | cpu_valid | cpu_exc);
      // A reset cycle must not leak a pending read or start a new access.
      if (reset) begin
         cpu_stall = 1'b0;
         cpu_valid = 1'b0;
         cpu_rdata = 32'd0;
         cpu_exc   = 1'b0;
         dma_gnt   = 1'b0;
         dma_valid = 1'b0;
         dma_rdata = 32'd0;
         mem_en    = 1'b0;
         mem_be    = 4'b0000;
         mem_addr  = '0;
         mem_wdata = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= DMA_IDLE;
         last_gnt_q <= OWN_DMA;
         rd_off_q   <= 2'd0;
         rd_lssl_q  <= 3'd0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         rd_off_q   <= rd_off_d;
         rd_lssl_q  <= rd_lssl_d;
      end
   end

endmodule

`default_nettype wire
